dot_vertical_ctrl: RTL and testbench
====================================

Name: dot_vertical_ctrl

Overview:
Consumer end of the flap interface. Takes the level-sensitive `up` command produced by the flap timer and turns it into the dot's vertical screen position. Position updates at a fixed step rate. The dot rises while `up` is high and falls under gravity while it is low. The block flags a crash when the dot reaches the floor. Its outputs feed the drawing logic and game control.

Parameters:
- STEP_DIV, 1000000, clk50 cycles per position step (50 steps/s at 50 MHz); must be ≥2.
- Y_MAX, 119, floor row (rows are numbered 0 = top to Y_MAX = bottom).
- Y_START, 60, row loaded at reset and on start/restart.
- FALL_VMAX, 4, maximum fall speed in rows/step.
- Y_W, 7, width of dot_y.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- up  in  1  1 = rise, 0 = fall; driven by the flap timer and synchronous to clk50.
- start  in  1  single-cycle pulse that starts or restarts play.
- dot_y  out  Y_W  current dot row.
- step  out  1  one-cycle pulse on every position update cycle; used for redraw.
- playing  out  1  high while in state FLY.
- crashed  out  1  high while in state CRASH.

Behaviour:
Reset (any state, including mid-flight):
- State = IDLE, dot_y = Y_START, vel = 1, prescaler = 0.
- step = 0, playing = 0, crashed = 0.
- All effects take hold on the next clk50 edge.

Prescaler:
- Counts 0..STEP_DIV-1 and wraps to 0.
- tick = (prescaler == STEP_DIV-1) and state == FLY.
- The prescaler is cleared to 0 on reset and on any accepted start.

States:
- IDLE: dot holds at Y_START. `start` → FLY.
- FLY:
  - playing = 1.
  - On tick with up = 1: dot_y = max(dot_y - 1, 0), saturating at the ceiling; no crash; vel = 1.
  - On tick with up = 0: compute sum = dot_y + vel at Y_W+1 bits so it cannot wrap.
    - If sum ≥ Y_MAX: dot_y = Y_MAX and state → CRASH.
    - Otherwise dot_y = sum, and vel = min(vel + 1, FALL_VMAX) (see GRAVITY_ACCEL_EN).
  - Without a tick, dot_y and vel hold.
- CRASH:
  - crashed = 1 and dot_y holds at Y_MAX.
  - `start` → FLY with dot_y = Y_START, vel = 1, prescaler = 0.

Start handling:
- A start accepted from IDLE or CRASH moves to FLY on the next edge.
- start during FLY is ignored.

Timing:
- step is registered: it is high in the cycle after the tick, together with the new dot_y.
- The crash transition and its step pulse occur on the same edge.
- up is sampled only in the tick cycle. Changes between ticks have no effect.

Simultaneous events:
- reset beats start.
- start coinciding with a tick in IDLE/CRASH is an entry into FLY; no move happens that cycle.

Widths:
- vel is a clog2(FALL_VMAX+1)-bit register with minimum value 1.
- Y_MAX must be < 2^Y_W.

Optional Feature:
Macro: GRAVITY_ACCEL_EN.
- Defined: fall speed accelerates as described. vel increments by 1 per falling tick up to FALL_VMAX and returns to 1 on any rising tick or restart.
- Undefined: vel is tied to 1, so the dot falls a constant 1 row per tick. FALL_VMAX is unused and no vel register is synthesised.

Test Plan:
1. Reset and hold.
   - Stimulus: STEP_DIV=4; assert reset for 3 cycles, then release with start=0 for 20 cycles.
   - Required: dot_y=60, playing=0, crashed=0, step never asserted.
2. Rise and ceiling clamp.
   - Stimulus: start pulse, then up=1 held.
   - Required: dot_y decrements by 1 per step (step every 4 cycles) down to 0, then stays 0 with playing still 1.
3. Accelerated fall (macro defined).
   - Stimulus: start, up=0.
   - Required: dot_y sequence 61, 63, 66, 70, 74, 78, … (vel capped at 4).
   - On reaching ≥119: dot_y=119, crashed=1, playing=0, and the step pulse on the same edge.
4. Constant fall (macro undefined).
   - Stimulus: start, up=0.
   - Required: dot_y 61, 62, 63, … to 119; crash after exactly 59 steps.
5. Velocity reset by flap.
   - Stimulus: fall 3 ticks (vel=4), then up=1 for 1 tick, then up=0.
   - Required: dot_y 61, 63, 66, 65, 66 (fall restarts at vel=1).
   - Also: toggling up between ticks has no effect.
6. Restart and reset mid-flight.
   - Stimulus: in CRASH, pulse start.
   - Required: dot_y=60, playing=1, first step exactly 4 cycles later.
   - Stimulus: reset during FLY at dot_y=30.
   - Required: IDLE, dot_y=60 next cycle.
   - Stimulus: reset together with start.
   - Required: IDLE.

Source files
------------

// File: rtl/dot_vertical_ctrl.sv
// dot_vertical_ctrl: converts the level-sensitive flap command `up` into the
// dot's vertical screen row. The row advances once per STEP_DIV clocks while
// the game is in FLY. A crash is raised when the dot reaches the floor row.
//
// Optional feature macro: GRAVITY_ACCEL_EN
//   defined   -> fall speed grows by one row/step per falling step, up to FALL_VMAX
//   undefined -> the dot always falls one row per step and no velocity register exists
//
// Interface notes: `start` is a single-cycle pulse. It is accepted only in IDLE
// or CRASH and ignored in FLY. `step` is a one-cycle registered pulse that
// appears together with the updated dot_y. The FSM state is visible on
// state_dbg_o, encoded as IDLE=0, FLY=1, CRASH=2.
module dot_vertical_ctrl #(
  parameter int STEP_DIV  = 1000000,
  parameter int Y_MAX     = 119,
  parameter int Y_START   = 60,
  parameter int FALL_VMAX = 4,
  parameter int Y_W       = 7
) (
  input  logic           clk50,
  input  logic           reset,
  input  logic           up,
  input  logic           start,
  output logic [Y_W-1:0] dot_y,
  output logic           step,
  output logic           playing,
  output logic           crashed,
  output logic [1:0]     state_dbg_o
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int VW = (FALL_VMAX > 0) ? $clog2(FALL_VMAX + 1) : 1;

  localparam logic [PW-1:0]  PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [Y_W-1:0] Y_START_V  = Y_W'(Y_START);
  localparam logic [Y_W-1:0] Y_MAX_V    = Y_W'(Y_MAX);
  localparam logic [Y_W:0]   Y_MAX_EXT  = (Y_W + 1)'(Y_MAX);
  localparam logic [VW-1:0]  VEL_ONE    = VW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    CRASH = 2'd2
  } state_e;

  state_e         state_q;
  logic [PW-1:0]  presc_q;
  logic [Y_W-1:0] y_q;
  logic           step_q;

`ifdef GRAVITY_ACCEL_EN
  localparam logic [VW-1:0] VEL_MAX = VW'(FALL_VMAX);
  logic [VW-1:0] vel_q;
`else
  // Constant-speed fall: velocity is a fixed single row per step.
  logic [VW-1:0] vel_q;
  assign vel_q = VEL_ONE;
`endif

  logic           tick;
  logic [Y_W:0]   fall_sum_d;
  logic           start_ok;

  // Step strobe, the one-bit-wider fall target, and start acceptance.
  always_comb begin
    tick       = (presc_q == PRESC_LAST) && (state_q == FLY);
    fall_sum_d = {1'b0, y_q} + (Y_W + 1)'(vel_q);
    start_ok   = start && (state_q != FLY);
  end

  // Single FSM register block: prescaler, position, velocity, step strobe.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      y_q     <= Y_START_V;
      step_q  <= 1'b0;
`ifdef GRAVITY_ACCEL_EN
      vel_q   <= VEL_ONE;
`endif
    end else begin
      step_q  <= tick;
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      if (start_ok) begin
        // Entry into play takes priority over a coincident prescaler wrap.
        state_q <= FLY;
        presc_q <= '0;
        y_q     <= Y_START_V;
`ifdef GRAVITY_ACCEL_EN
        vel_q   <= VEL_ONE;
`endif
      end else if (tick) begin
        if (up) begin
          // Rise one row, pinned at the ceiling; any flap resets fall speed.
          if (y_q != '0) y_q <= y_q - 1'b1;
`ifdef GRAVITY_ACCEL_EN
          vel_q <= VEL_ONE;
`endif
        end else if (fall_sum_d >= Y_MAX_EXT) begin
          y_q     <= Y_MAX_V;
          state_q <= CRASH;
        end else begin
          y_q <= fall_sum_d[Y_W-1:0];
`ifdef GRAVITY_ACCEL_EN
          if (vel_q < VEL_MAX) vel_q <= vel_q + 1'b1;
`endif
        end
      end else if (state_q != IDLE && state_q != FLY && state_q != CRASH) begin
        state_q <= IDLE;
      end
    end
  end

  assign dot_y       = y_q;
  assign step        = step_q;
  assign playing     = (state_q == FLY);
  assign crashed     = (state_q == CRASH);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_dot_vertical_ctrl.sv
// Directed bench for dot_vertical_ctrl with STEP_DIV=4.
// Expected rows are hand-computed constants. Two sets are provided, one for the
// accelerating-fall build (GRAVITY_ACCEL_EN) and one for the constant-fall build.
module tb_dot_vertical_ctrl;

  localparam int STEP_DIV = 4;
  localparam int Y_W      = 7;

  logic           clk50;
  logic           reset;
  logic           up;
  logic           start;
  logic [Y_W-1:0] dot_y;
  logic           step;
  logic           playing;
  logic           crashed;
  logic [1:0]     state_dbg_o;

  int errors = 0;
  int checks = 0;

  logic [Y_W-1:0] exp_q[$];

  dot_vertical_ctrl #(
    .STEP_DIV (STEP_DIV),
    .Y_MAX    (119),
    .Y_START  (60),
    .FALL_VMAX(4),
    .Y_W      (Y_W)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .up         (up),
    .start      (start),
    .dot_y      (dot_y),
    .step       (step),
    .playing    (playing),
    .crashed    (crashed),
    .state_dbg_o(state_dbg_o)
  );

  // Clock and reset
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clk50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Advance until step is seen (bounded); returns edges taken.
  task automatic wait_step(input int already, output int n);
    n = already;
    do begin
      cycle();
      n++;
    end while (step !== 1'b1 && n < 16);
  endtask

  // One position step with the command u present at the tick edge; `up`
  // wanders during the three non-tick cycles before it.
  task automatic step_with(input logic u);
    int n;
    up = ~u;
    cycle();
    up = 1'($urandom_range(0, 1));
    cycle();
    up = ~u;
    cycle();
    up = u;
    wait_step(3, n);
    check("step_period", n, 4);
  endtask

  initial begin : stim
    logic [Y_W-1:0] exp_y;
    logic [Y_W-1:0] seq5[5];
    logic           ups5[5];
    int             nstep;
    int             n;

    reset = 1'b1;
    up    = 1'b0;
    start = 1'b0;

    // 1. reset and hold
    repeat (3) cycle();
    check("rst_dot_y", dot_y, 60);
    check("rst_playing", playing, 0);
    check("rst_crashed", crashed, 0);
    check("rst_step", step, 0);
    check("rst_state", state_dbg_o, 0);
    reset = 1'b0;
    nstep = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (step === 1'b1) nstep++;
    end
    check("idle_steps", nstep, 0);
    check("idle_dot_y", dot_y, 60);
    check("idle_playing", playing, 0);
    check("idle_crashed", crashed, 0);

    // 2. rise and ceiling clamp
    pulse_start();
    check("start_playing", playing, 1);
    check("start_dot_y", dot_y, 60);
    check("start_step", step, 0);
    for (int r = 59; r >= 0; r--) begin
      step_with(1'b1);
      check("rise_y", dot_y, r);
    end
    for (int i = 0; i < 3; i++) begin
      step_with(1'b1);
      check("ceil_y", dot_y, 0);
      check("ceil_playing", playing, 1);
    end
    // start during FLY is ignored: phase and position unaffected
    pulse_start();
    check("fly_start_y", dot_y, 0);
    up = 1'b1;
    wait_step(1, n);
    check("fly_start_period", n, 4);
    check("fly_start_y2", dot_y, 0);

    // reset mid-flight returns to IDLE at the start row on the next edge
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midrst_state", state_dbg_o, 0);
    check("midrst_dot_y", dot_y, 60);
    check("midrst_playing", playing, 0);

    // 3/4. fall to crash
`ifdef GRAVITY_ACCEL_EN
    exp_q.push_back(7'd61);
    exp_q.push_back(7'd63);
    exp_q.push_back(7'd66);
    for (int v = 70; v <= 118; v += 4) exp_q.push_back(7'(v));
    exp_q.push_back(7'd119);
`else
    for (int v = 61; v <= 119; v++) exp_q.push_back(7'(v));
`endif
    pulse_start();
    while (exp_q.size() > 0) begin
      exp_y = exp_q.pop_front();
      step_with(1'b0);
      check("fall_y", dot_y, exp_y);
      if (exp_q.size() == 0) begin
        check("crash_crashed", crashed, 1);
        check("crash_playing", playing, 0);
        check("crash_step", step, 1);
        check("crash_state", state_dbg_o, 2);
      end else begin
        check("fall_crashed", crashed, 0);
      end
    end
    nstep = 0;
    for (int i = 0; i < 10; i++) begin
      up = 1'($urandom_range(0, 1));
      cycle();
      if (step === 1'b1) nstep++;
    end
    check("crash_hold_steps", nstep, 0);
    check("crash_hold_y", dot_y, 119);
    check("crash_hold_crashed", crashed, 1);

    // 6a/5. restart from CRASH then flap resets fall speed
    pulse_start();
    check("restart_y", dot_y, 60);
    check("restart_playing", playing, 1);
    check("restart_crashed", crashed, 0);
`ifdef GRAVITY_ACCEL_EN
    seq5 = '{7'd61, 7'd63, 7'd66, 7'd65, 7'd66};
`else
    seq5 = '{7'd61, 7'd62, 7'd63, 7'd62, 7'd63};
`endif
    ups5 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step_with(ups5[i]);
      check("vel_seq_y", dot_y, seq5[i]);
    end

    // 6b. rise to row 30, then reset in FLY
    exp_y = seq5[4];
    while (exp_y > 7'd30) begin
      exp_y = exp_y - 7'd1;
      step_with(1'b1);
      check("rise30_y", dot_y, exp_y);
    end
    reset = 1'b1;
    cycle();
    check("rst30_state", state_dbg_o, 0);
    check("rst30_dot_y", dot_y, 60);
    check("rst30_step", step, 0);

    // reset wins over a coincident start
    start = 1'b1;
    cycle();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_state", state_dbg_o, 0);
    check("rst_start_playing", playing, 0);
    cycle();
    check("rst_start_after", state_dbg_o, 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
